// File: rtl/crb_transfer_engine.sv
// CRB transfer engine: copies a command out of the TPM I/O FIFO into a local
// command/response memory, lends that memory to the execution engine, then
// streams the response back into the FIFO.
module crb_transfer_engine #(
    parameter int BUF_SIZE = 4096,
    parameter int ADDR_W   = $clog2(BUF_SIZE)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              f_abort,
    input  logic              c_cmdSend,
    input  logic [31:0]       c_cmdSize,
    input  logic [7:0]        cmdByteIn,
    output logic [ADDR_W-1:0] c_cmdInAddr,
    output logic              c_cmdDone,
    output logic [7:0]        rspByteOut,
    output logic [ADDR_W-1:0] c_rspInAddr,
    output logic              c_rspSend,
    output logic              c_rspDone,
    output logic [31:0]       c_rspSize,
    output logic              e_execStart,
    output logic [31:0]       e_cmdLen,
    input  logic              e_execDone,
    input  logic [31:0]       e_rspSize,
    input  logic [ADDR_W-1:0] e_addr,
    input  logic [7:0]        e_wrByte,
    input  logic              e_wren_n,
    output logic [7:0]        e_rdByte,
    output logic              xfer_err
);

    localparam logic [31:0]       BUF_LEN = 32'(BUF_SIZE);
    localparam logic [ADDR_W:0]   C_ONE   = 1;
    localparam logic [ADDR_W-1:0] A_ONE   = 1;

    typedef enum logic [3:0] {
        IDLE, CMD_XFER, CMD_LAST, CMD_DONE, EXEC,
        RSP_LATCH, RSP_PRIME, RSP_XFER, RSP_DONE
    } state_t;

    state_t state, state_nxt;
    // One bit wider than an address so a full BUF_SIZE transfer ends without wrapping.
    logic [ADDR_W:0]   count, count_nxt;
    logic [ADDR_W:0]   cmd_last, rsp_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata, rd_data;
    logic [7:0]        mem [BUF_SIZE];

    function automatic logic [31:0] clamp(input logic [31:0] size);
        return (size > BUF_LEN) ? BUF_LEN : size;
    endfunction

    assign cmd_last = e_cmdLen[ADDR_W:0] - C_ONE;
    assign rsp_last = c_rspSize[ADDR_W:0] - C_ONE;

    // State and transfer counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // Latched lengths and the sticky overflow flag; abort leaves them untouched.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            e_cmdLen  <= '0;
            c_rspSize <= '0;
            xfer_err  <= 1'b0;
        end else if (!f_abort) begin
            if (state == IDLE && c_cmdSend) begin
                e_cmdLen <= clamp(c_cmdSize);
                xfer_err <= (c_cmdSize > BUF_LEN);
            end else if (state == EXEC && e_execDone) begin
                c_rspSize <= clamp(e_rspSize);
                if (e_rspSize > BUF_LEN) xfer_err <= 1'b1;
            end
        end
    end

    // Next state, counter and memory port mux (exec owns the port only in EXEC).
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = cmdByteIn;
        case (state)
            IDLE: if (c_cmdSend) begin
                count_nxt = '0;
                state_nxt = (clamp(c_cmdSize) == '0) ? CMD_DONE : CMD_XFER;
            end
            CMD_XFER: begin
                // Data for the previous address arrives this cycle.
                mem_we    = (count != '0);
                mem_addr  = count[ADDR_W-1:0] - A_ONE;
                count_nxt = count + C_ONE;
                if (count == cmd_last) state_nxt = CMD_LAST;
            end
            CMD_LAST: begin
                mem_we    = 1'b1;
                mem_addr  = cmd_last[ADDR_W-1:0];
                state_nxt = CMD_DONE;
            end
            CMD_DONE: state_nxt = EXEC;
            EXEC: begin
                mem_we    = !e_wren_n;
                mem_addr  = e_addr;
                mem_wdata = e_wrByte;
                if (e_execDone) state_nxt = RSP_LATCH;
            end
            RSP_LATCH: begin
                count_nxt = '0;
                state_nxt = RSP_PRIME;
            end
            RSP_PRIME: begin
                mem_addr  = '0;
                state_nxt = (c_rspSize == '0) ? RSP_DONE : RSP_XFER;
            end
            RSP_XFER: begin
                // Prefetch the next byte so it is ready on the following cycle.
                mem_addr = count[ADDR_W-1:0] + A_ONE;
                if (count == rsp_last) state_nxt = RSP_DONE;
                else                   count_nxt = count + C_ONE;
            end
            RSP_DONE: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
        if (f_abort) begin
            state_nxt = IDLE;
            mem_we    = 1'b0;
        end
    end

    // Single-port RAM with registered read.
    always_ff @(posedge clock) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        rd_data <= mem[mem_addr];
    end

    assign e_rdByte    = rd_data;
    assign c_cmdInAddr = (state == CMD_XFER) ? count[ADDR_W-1:0] : '0;
    assign c_rspInAddr = (state == RSP_XFER) ? count[ADDR_W-1:0] : '0;
    assign c_cmdDone   = (state == CMD_DONE) && !f_abort;
    assign e_execStart = (state == CMD_DONE) && !f_abort;
    assign c_rspDone   = (state == RSP_DONE) && !f_abort;
    assign c_rspSend   = !((state == RSP_XFER) && !f_abort);
    assign rspByteOut  = ((state == RSP_XFER) && !f_abort) ? rd_data : 8'hFF;

endmodule

// File: tb/tb_crb_transfer_engine.sv
// Directed bench for crb_transfer_engine: command copy, exec memory access,
// response stream, clamping, abort and ignored-handshake cases.
module tb_crb_transfer_engine;

    localparam int BUF_SIZE = 4096;
    localparam int ADDR_W   = 12;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              f_abort;
    logic              c_cmdSend;
    logic [31:0]       c_cmdSize;
    logic [7:0]        cmdByteIn;
    logic [ADDR_W-1:0] c_cmdInAddr;
    logic              c_cmdDone;
    logic [7:0]        rspByteOut;
    logic [ADDR_W-1:0] c_rspInAddr;
    logic              c_rspSend;
    logic              c_rspDone;
    logic [31:0]       c_rspSize;
    logic              e_execStart;
    logic [31:0]       e_cmdLen;
    logic              e_execDone;
    logic [31:0]       e_rspSize;
    logic [ADDR_W-1:0] e_addr;
    logic [7:0]        e_wrByte;
    logic              e_wren_n;
    logic [7:0]        e_rdByte;
    logic              xfer_err;

    int checks = 0;
    int errors = 0;

    crb_transfer_engine #(.BUF_SIZE(BUF_SIZE), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset_n(reset_n), .f_abort(f_abort),
        .c_cmdSend(c_cmdSend), .c_cmdSize(c_cmdSize), .cmdByteIn(cmdByteIn),
        .c_cmdInAddr(c_cmdInAddr), .c_cmdDone(c_cmdDone), .rspByteOut(rspByteOut),
        .c_rspInAddr(c_rspInAddr), .c_rspSend(c_rspSend), .c_rspDone(c_rspDone),
        .c_rspSize(c_rspSize), .e_execStart(e_execStart), .e_cmdLen(e_cmdLen),
        .e_execDone(e_execDone), .e_rspSize(e_rspSize), .e_addr(e_addr),
        .e_wrByte(e_wrByte), .e_wren_n(e_wren_n), .e_rdByte(e_rdByte),
        .xfer_err(xfer_err)
    );

    always #5 clock = ~clock;

    // FIFO read model: data for an address appears one cycle later.
    always @(posedge clock) cmdByteIn <= c_cmdInAddr[7:0] ^ 8'hA5;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [ADDR_W-1:0] a, input logic [7:0] exp);
        e_addr = a;
        step();
        check(tag, {24'd0, e_rdByte}, {24'd0, exp});
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        e_addr   = a;
        e_wrByte = d;
        e_wren_n = 1'b0;
        step();
        e_wren_n = 1'b1;
    endtask

    task automatic send_cmd(input logic [31:0] size);
        c_cmdSize = size;
        c_cmdSend = 1'b1;
        step();
        c_cmdSend = 1'b0;
    endtask

    logic [7:0] rsp_exp [6];
    int bad;
    int seen_low;

    initial begin
        rsp_exp = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h06};
        reset_n = 1'b0; f_abort = 1'b0; c_cmdSend = 1'b0; c_cmdSize = '0;
        e_execDone = 1'b0; e_rspSize = '0; e_addr = '0; e_wrByte = '0; e_wren_n = 1'b1;
        #2;
        check("rst_rspSend", {31'd0, c_rspSend}, 32'd1);
        check("rst_rspByte", {24'd0, rspByteOut}, 32'hFF);
        check("rst_cmdDone", {31'd0, c_cmdDone}, 32'd0);
        check("rst_cmdLen", e_cmdLen, 32'd0);
        check("rst_xfer_err", {31'd0, xfer_err}, 32'd0);
        step(); step();
        reset_n = 1'b1;
        step();

        // Oversized command: clamped to 4096, error flagged, addresses 0..4095.
        send_cmd(32'd5000);
        check("big_cmdLen", e_cmdLen, 32'd4096);
        check("big_err", {31'd0, xfer_err}, 32'd1);
        bad = 0;
        for (int i = 1; i <= 4096; i++) begin
            if (c_cmdInAddr !== ADDR_W'(i - 1) || c_cmdDone !== 1'b0) bad++;
            if (i == 4096) check("big_last_addr", {20'd0, c_cmdInAddr}, 32'd4095);
            step();
        end
        check("big_addr_seq", bad, 0);
        check("big_cmdlast_nodone", {31'd0, c_cmdDone}, 32'd0);
        step();
        check("big_cmdDone", {31'd0, c_cmdDone}, 32'd1);
        step();
        rd_chk("big_mem0", 12'd0, 8'hA5);
        rd_chk("big_mem4095", 12'd4095, 8'h5A);
        e_rspSize = 0; e_execDone = 1'b1; step(); e_execDone = 1'b0;
        step(); step();
        check("big_rspDone", {31'd0, c_rspDone}, 32'd1);
        step();

        // 10-byte command: clears the error, done at cycle 12.
        send_cmd(32'd10);
        check("c10_err_clr", {31'd0, xfer_err}, 32'd0);
        check("c10_cmdLen", e_cmdLen, 32'd10);
        bad = 0;
        for (int i = 1; i <= 11; i++) begin
            if (i <= 10 && c_cmdInAddr !== ADDR_W'(i - 1)) bad++;
            if (c_cmdDone !== 1'b0 || e_execStart !== 1'b0) bad++;
            step();
        end
        check("c10_addr_seq", bad, 0);
        check("c10_cmdDone", {31'd0, c_cmdDone}, 32'd1);
        check("c10_execStart", {31'd0, e_execStart}, 32'd1);
        step();
        check("c10_cmdDone_drop", {31'd0, c_cmdDone}, 32'd0);
        for (int k = 0; k < 10; k++) rd_chk("c10_mem", 12'(k), 8'(k) ^ 8'hA5);

        // Exec writes a 6-byte response and it streams back to the FIFO.
        for (int k = 0; k < 6; k++) wr(12'(k), rsp_exp[k]);
        e_rspSize = 32'd6; e_execDone = 1'b1;
        step();
        e_execDone = 1'b0;
        check("r6_rspSize", c_rspSize, 32'd6);
        check("r6_c1_send", {31'd0, c_rspSend}, 32'd1);
        step();
        check("r6_c2_send", {31'd0, c_rspSend}, 32'd1);
        step();
        for (int k = 0; k < 6; k++) begin
            check("r6_send_low", {31'd0, c_rspSend}, 32'd0);
            check("r6_addr", {20'd0, c_rspInAddr}, 32'(k));
            check("r6_byte", {24'd0, rspByteOut}, {24'd0, rsp_exp[k]});
            step();
        end
        check("r6_rspDone", {31'd0, c_rspDone}, 32'd1);
        check("r6_done_send", {31'd0, c_rspSend}, 32'd1);
        step();
        check("r6_rspDone_drop", {31'd0, c_rspDone}, 32'd0);

        // e_execDone while Idle is ignored.
        e_rspSize = 32'd3; e_execDone = 1'b1; step(); e_execDone = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (c_rspSend !== 1'b1 || c_rspDone !== 1'b0) bad++;
            step();
        end
        check("idle_execDone_ign", bad, 0);
        check("idle_rspSize_hold", c_rspSize, 32'd6);

        // Zero-length command, then c_cmdSend during Exec, then zero response.
        send_cmd(32'd0);
        check("z_cmdDone", {31'd0, c_cmdDone}, 32'd1);
        check("z_cmdInAddr", {20'd0, c_cmdInAddr}, 32'd0);
        step();
        send_cmd(32'd3);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (c_cmdDone !== 1'b0 || c_cmdInAddr !== '0) bad++;
            step();
        end
        check("exec_cmdSend_ign", bad, 0);
        check("exec_cmdLen_hold", e_cmdLen, 32'd0);
        e_rspSize = 32'd0; e_execDone = 1'b1; step(); e_execDone = 1'b0;
        seen_low = 0;
        if (c_rspSend !== 1'b1) seen_low++;
        step();
        if (c_rspSend !== 1'b1) seen_low++;
        step();
        if (c_rspSend !== 1'b1) seen_low++;
        check("z_rspDone", {31'd0, c_rspDone}, 32'd1);
        check("z_send_never_low", seen_low, 0);
        step();

        // Abort at counter 4 of an 8-byte command.
        send_cmd(32'd8);
        for (int i = 1; i < 5; i++) step();
        check("ab_addr4", {20'd0, c_cmdInAddr}, 32'd4);
        f_abort = 1'b1;
        #1;
        check("ab_send_hi", {31'd0, c_rspSend}, 32'd1);
        step();
        f_abort = 1'b0;
        check("ab_idle_addr", {20'd0, c_cmdInAddr}, 32'd0);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (c_cmdDone !== 1'b0 || c_rspSend !== 1'b1) bad++;
            step();
        end
        check("ab_no_done", bad, 0);
        send_cmd(32'd3);
        for (int i = 1; i <= 4; i++) step();
        check("f3_cmdDone", {31'd0, c_cmdDone}, 32'd1);
        check("f3_cmdLen", e_cmdLen, 32'd3);
        step();
        rd_chk("f3_mem0", 12'd0, 8'hA5);
        rd_chk("f3_mem1", 12'd1, 8'hA4);
        rd_chk("f3_mem2", 12'd2, 8'hA7);
        rd_chk("ab_write_suppressed", 12'd3, 8'h00);
        e_rspSize = 32'd0; e_execDone = 1'b1; step(); e_execDone = 1'b0;
        step(); step();
        check("f3_rspDone", {31'd0, c_rspDone}, 32'd1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
